// File: rtl/fpro_dbg_master.sv
// UART-driven debug initiator for the FPro MMIO bus: decodes 'W'/'R' frames from a byte
// stream, issues one bus transaction per frame and returns the reply bytes to a UART tx core.
module fpro_dbg_master #(
  parameter int unsigned TO_CYCLES = 1_000_000,
  parameter logic [7:0]  ACK_BYTE  = 8'h2B,
  parameter logic [7:0]  ERR_BYTE  = 8'h21
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        fp_mmio_cs,
  output logic        fp_wr,
  output logic        fp_rd,
  output logic [20:0] fp_addr,
  output logic [31:0] fp_wr_data,
  input  logic [31:0] fp_rd_data,
  output logic        busy,
  output logic        frame_err
);

  localparam int unsigned TW = $clog2(TO_CYCLES + 1);
  localparam int unsigned AW = 21;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_BUS_WR = 3'd3;
  localparam logic [2:0] S_BUS_RD = 3'd4;
  localparam logic [2:0] S_SEND   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          op_wr_q, op_wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [AW-1:0] addr_sh_q, addr_sh_d;
  logic [23:0]   wdata_sh_q, wdata_sh_d;
  logic [23:0]   txbuf_q, txbuf_d;
  logic [AW-1:0] fp_addr_q, fp_addr_d;
  logic [DW-1:0] fp_wr_data_q, fp_wr_data_d;
  logic          cs_q, cs_d;
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;
  logic          to_hit_c;

  assign to_hit_c = (to_cnt_q == TW'(TO_CYCLES - 1));

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_wr_q      <= 1'b0;
      cnt_q        <= '0;
      to_cnt_q     <= '0;
      addr_sh_q    <= '0;
      wdata_sh_q   <= '0;
      txbuf_q      <= '0;
      fp_addr_q    <= '0;
      fp_wr_data_q <= '0;
      cs_q         <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_wr_q      <= op_wr_d;
      cnt_q        <= cnt_d;
      to_cnt_q     <= to_cnt_d;
      addr_sh_q    <= addr_sh_d;
      wdata_sh_q   <= wdata_sh_d;
      txbuf_q      <= txbuf_d;
      fp_addr_q    <= fp_addr_d;
      fp_wr_data_q <= fp_wr_data_d;
      cs_q         <= cs_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state and next-output logic; the timeout counter only runs while collecting a frame
  always_comb begin
    state_d      = state_q;
    op_wr_d      = op_wr_q;
    cnt_d        = cnt_q;
    to_cnt_d     = '0;
    addr_sh_d    = addr_sh_q;
    wdata_sh_d   = wdata_sh_q;
    txbuf_d      = txbuf_q;
    fp_addr_d    = fp_addr_q;
    fp_wr_data_d = fp_wr_data_q;
    cs_d         = 1'b0;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          cnt_d = '0;
          if (rx_data == OP_WR) begin
            state_d = S_ADDR;
            op_wr_d = 1'b1;
          end else if (rx_data == OP_RD) begin
            state_d = S_ADDR;
            op_wr_d = 1'b0;
          end else begin
            state_d    = S_SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = ERR_BYTE;
          end
        end
      end

      S_ADDR: begin
        if (rx_valid) begin
          addr_sh_d = {addr_sh_q[12:0], rx_data};
          if (cnt_q == CW'(2)) begin
            cnt_d = '0;
            if (op_wr_q) begin
              state_d = S_DATA;
            end else begin
              state_d   = S_BUS_RD;
              fp_addr_d = {addr_sh_q[12:0], rx_data};
              cs_d      = 1'b1;
              rd_d      = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (to_hit_c) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          op_wr_d     = 1'b0;
          cnt_d       = '0;
          addr_sh_d   = '0;
          wdata_sh_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          wdata_sh_d = {wdata_sh_q[15:0], rx_data};
          if (cnt_q == CW'(3)) begin
            cnt_d        = '0;
            state_d      = S_BUS_WR;
            fp_addr_d    = addr_sh_q;
            fp_wr_data_d = {wdata_sh_q, rx_data};
            cs_d         = 1'b1;
            wr_d         = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (to_hit_c) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          op_wr_d     = 1'b0;
          cnt_d       = '0;
          addr_sh_d   = '0;
          wdata_sh_d  = '0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_BUS_WR: begin
        state_d    = S_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = ACK_BYTE;
        cnt_d      = '0;
      end

      // Read data is sampled here; the MSB goes out first, the rest waits in txbuf
      S_BUS_RD: begin
        state_d    = S_SEND;
        tx_valid_d = 1'b1;
        tx_data_d  = fp_rd_data[31:24];
        txbuf_d    = fp_rd_data[23:0];
        cnt_d      = CW'(3);
      end

      // cnt holds the number of bytes still to follow the one on tx_data
      S_SEND: begin
        if (tx_valid_q && tx_ready) begin
          if (cnt_q == '0) begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end else begin
            tx_data_d = txbuf_q[23:16];
            txbuf_d   = {txbuf_q[15:0], 8'h00};
            cnt_d     = cnt_q - CW'(1);
          end
        end
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        cnt_d      = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign fp_mmio_cs = cs_q;
  assign fp_wr      = wr_q;
  assign fp_rd      = rd_q;
  assign fp_addr    = fp_addr_q;
  assign fp_wr_data = fp_wr_data_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;

endmodule
